// File: rtl/car_shaft_model.sv
// -----------------------------------------------------------------------------
// car_shaft_model
//   Cycle-accurate, synthesizable plant model of a 3-floor lift car and shaft.
//   It answers the movement controller's engine/door commands with car
//   position, floor alignment sensors, door state and an arrival strobe, so
//   controller benches and board demos can run closed-loop without hardware.
//
// Ports
//   CLK          in   system clock, all state changes on its rising edge
//   RST          in   asynchronous active-low reset
//   My_Clock     in   slow tick strobe; each CLK cycle it is high is one tick
//   engine[1:0]  in   00 stop, 01 up, 10 down, 11 illegal (flagged, acts as 00)
//   doors[2:0]   in   one-hot door-open request, bit i = floor i
//   position     out  last floor aligned at or departed from (0..2)
//   floor_sensor out  one-hot alignment sensor, 000 while between floors
//   door_open    out  one-hot actual door state
//   moving       out  high while the car is travelling
//   arrived      out  one-CLK pulse when the car becomes aligned at a floor
//   fault        out  sticky illegal-command flag, cleared only by RST
// -----------------------------------------------------------------------------
module car_shaft_model #(
  parameter int FLOORS       = 3,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              My_Clock,
  input  logic [1:0]        engine,
  input  logic [FLOORS-1:0] doors,
  output logic [1:0]        position,
  output logic [FLOORS-1:0] floor_sensor,
  output logic [FLOORS-1:0] door_open,
  output logic              moving,
  output logic              arrived,
  output logic              fault
);

  localparam logic [3:0] TRAVEL_INIT = 4'(TRAVEL_TICKS);
  localparam logic [3:0] DOOR_INIT   = 4'(DOOR_TICKS);
  localparam logic [1:0] TOP_FLOOR   = 2'(FLOORS - 1);

  typedef enum logic [2:0] {
    ALIGNED      = 3'd0,
    TRAVEL       = 3'd1,
    HALTED       = 3'd2,
    DOOR_OPENING = 3'd3,
    DOOR_OPEN    = 3'd4
  } state_e;

  state_e            state_q,     state_d;
  logic [1:0]        pos_q,       pos_d;
  logic [1:0]        target_q,    target_d;
  logic              dir_up_q,    dir_up_d;
  logic [3:0]        rem_q,       rem_d;
  logic [3:0]        door_cnt_q,  door_cnt_d;
  logic [FLOORS-1:0] door_open_q, door_open_d;
  logic              arrived_q,   arrived_d;
  logic              fault_q,     fault_d;

  function automatic logic [FLOORS-1:0] onehot(input logic [1:0] p);
    onehot = {{(FLOORS-1){1'b0}}, 1'b1} << p;
  endfunction

  logic              eng_up, eng_dn, eng_bad;
  logic              eng_same, eng_opp;
  logic [FLOORS-1:0] door_here;
  logic              doors_bad;
  logic              doors_held;

  always_comb begin
    eng_up     = (engine == 2'b01);
    eng_dn     = (engine == 2'b10);
    eng_bad    = (engine == 2'b11);
    // Direction match relative to the current travel direction.
    eng_same   = (dir_up_q && eng_up) || (!dir_up_q && eng_dn);
    eng_opp    = (dir_up_q && eng_dn) || (!dir_up_q && eng_up);
    door_here  = onehot(pos_q);
    // Any request other than "just this floor" is illegal.
    doors_bad  = (doors != '0) && (doors != door_here);
    doors_held = ((doors & door_here) != '0);
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    target_d    = target_q;
    dir_up_d    = dir_up_q;
    rem_d       = rem_q;
    door_cnt_d  = door_cnt_q;
    door_open_d = door_open_q;
    arrived_d   = 1'b0;
    fault_d     = fault_q;

    if (eng_bad) fault_d = 1'b1;

    unique case (state_q)
      ALIGNED: begin
        if (doors_bad) fault_d = 1'b1;
        if (eng_up) begin
          if (pos_q < TOP_FLOOR) begin
            state_d  = TRAVEL;
            dir_up_d = 1'b1;
            target_d = pos_q + 2'd1;
            rem_d    = TRAVEL_INIT;
          end else begin
            fault_d = 1'b1;
          end
        end else if (eng_dn) begin
          if (pos_q > 2'd0) begin
            state_d  = TRAVEL;
            dir_up_d = 1'b0;
            target_d = pos_q - 2'd1;
            rem_d    = TRAVEL_INIT;
          end else begin
            fault_d = 1'b1;
          end
        end else if (doors == door_here) begin
          state_d    = DOOR_OPENING;
          door_cnt_d = DOOR_INIT;
        end
      end

      TRAVEL: begin
        if (doors != '0) fault_d = 1'b1;
        // A tick on the last remaining count always completes the hop,
        // whatever the engine does on that same edge.
        if (My_Clock && (rem_q <= 4'd1)) begin
          state_d   = ALIGNED;
          pos_d     = target_q;
          rem_d     = 4'd0;
          arrived_d = 1'b1;
        end else begin
          if (My_Clock) rem_d = rem_q - 4'd1;
          // Stop, illegal or reverse all halt the car first; reversing is
          // resolved from HALTED so the remaining distance is re-derived once.
          if (!eng_same) state_d = HALTED;
        end
      end

      HALTED: begin
        if (doors != '0) fault_d = 1'b1;
        if (eng_same) begin
          state_d = TRAVEL;
        end else if (eng_opp) begin
          // Head back to the floor just left: distance already covered
          // becomes the distance still to go.
          state_d  = TRAVEL;
          dir_up_d = !dir_up_q;
          target_d = dir_up_q ? (target_q - 2'd1) : (target_q + 2'd1);
          rem_d    = TRAVEL_INIT - rem_q;
        end
      end

      DOOR_OPENING: begin
        if (doors_bad || (engine != 2'b00)) fault_d = 1'b1;
        if (!doors_held) begin
          state_d    = ALIGNED;
          door_cnt_d = 4'd0;
        end else if (My_Clock) begin
          if (door_cnt_q <= 4'd1) begin
            state_d     = DOOR_OPEN;
            door_cnt_d  = 4'd0;
            door_open_d = door_here;
          end else begin
            door_cnt_d = door_cnt_q - 4'd1;
          end
        end
      end

      DOOR_OPEN: begin
        if (doors_bad || (engine != 2'b00)) fault_d = 1'b1;
        if (!doors_held) begin
          state_d     = ALIGNED;
          door_open_d = '0;
        end
      end

      default: state_d = ALIGNED;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ALIGNED;
      pos_q       <= 2'd0;
      target_q    <= 2'd0;
      dir_up_q    <= 1'b1;
      rem_q       <= 4'd0;
      door_cnt_q  <= 4'd0;
      door_open_q <= '0;
      arrived_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      target_q    <= target_d;
      dir_up_q    <= dir_up_d;
      rem_q       <= rem_d;
      door_cnt_q  <= door_cnt_d;
      door_open_q <= door_open_d;
      arrived_q   <= arrived_d;
      fault_q     <= fault_d;
    end
  end

  // Sensor and motion outputs follow the state register directly so that an
  // asynchronous reset shows on them without waiting for a clock edge.
  always_comb begin
    position     = pos_q;
    floor_sensor = ((state_q == TRAVEL) || (state_q == HALTED)) ? '0 : onehot(pos_q);
    door_open    = door_open_q;
    moving       = (state_q == TRAVEL);
    arrived      = arrived_q;
    fault        = fault_q;
  end

endmodule

// File: tb/tb_car_shaft_model.sv
module tb_car_shaft_model;

  logic       CLK;
  logic       RST;
  logic       My_Clock;
  logic [1:0] engine;
  logic [2:0] doors;
  logic [1:0] position;
  logic [2:0] floor_sensor;
  logic [2:0] door_open;
  logic       moving;
  logic       arrived;
  logic       fault;

  car_shaft_model #(
    .FLOORS      (3),
    .TRAVEL_TICKS(4),
    .DOOR_TICKS  (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .My_Clock    (My_Clock),
    .engine      (engine),
    .doors       (doors),
    .position    (position),
    .floor_sensor(floor_sensor),
    .door_open   (door_open),
    .moving      (moving),
    .arrived     (arrived),
    .fault       (fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One record: optional reset pulse, inputs held for idle+1 cycles with the
  // tick (if any) only on the final cycle, then the outputs expected after it.
  typedef struct {
    logic       rst;
    logic [1:0] eng;
    logic [2:0] drs;
    int         idle;
    logic       tk;
    logic [1:0] pos;
    logic [2:0] fs;
    logic [2:0] dop;
    logic       mv;
    logic       arr;
    logic       flt;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [10:0] RESET_EXP = {2'd0, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0};

  function automatic logic [10:0] outs();
    return {position, floor_sensor, door_open, moving, arrived, fault};
  endfunction

  task automatic add(input logic r, input logic [1:0] e, input logic [2:0] d,
                     input int idle, input logic tk, input logic [1:0] pos,
                     input logic [2:0] fs, input logic [2:0] dop,
                     input logic mv, input logic arr, input logic flt);
    vec_t v;
    v.rst = r;  v.eng = e;  v.drs = d;  v.idle = idle; v.tk = tk;
    v.pos = pos; v.fs = fs; v.dop = dop; v.mv = mv; v.arr = arr; v.flt = flt;
    vt.push_back(v);
  endtask

  task automatic check(input string nm, input logic [10:0] got, input logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got pos=%0d fs=%b door=%b mv=%b arr=%b flt=%b, expected pos=%0d fs=%b door=%b mv=%b arr=%b flt=%b",
               nm, got[10:9], got[8:6], got[5:3], got[2], got[1], got[0],
               exp[10:9], exp[8:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Called at posedge+1; reset is released well before the next edge.
  task automatic pulse_reset();
    RST = 1'b0;
    #2;
    RST = 1'b1;
  endtask

  task automatic cycle(input logic tk);
    My_Clock = tk;
    @(posedge CLK);
    #1;
    My_Clock = 1'b0;
  endtask

  initial begin
    RST = 1'b0; My_Clock = 1'b0; engine = 2'b00; doors = 3'b000;

    // Test 1: climb 0->1->2 with a tick every 4 CLK
    add(0, 2'b01, 3'b000, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 2, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 3, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 3, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 3, 1, 2'd1, 3'b010, 3'b000, 0, 1, 0);
    add(0, 2'b01, 3'b000, 0, 0, 2'd1, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 2, 1, 2'd1, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 3, 1, 2'd1, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 3, 1, 2'd1, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 3, 1, 2'd2, 3'b100, 3'b000, 0, 1, 0);
    // Test 2: up at the top floor is a fault, no motion, sticky
    add(0, 2'b01, 3'b000, 0, 0, 2'd2, 3'b100, 3'b000, 0, 0, 1);
    add(0, 2'b01, 3'b000, 3, 1, 2'd2, 3'b100, 3'b000, 0, 0, 1);
    add(0, 2'b00, 3'b000, 0, 0, 2'd2, 3'b100, 3'b000, 0, 0, 1);
    // Test 3: doors at floor 1
    add(1, 2'b01, 3'b000, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 0, 1, 2'd1, 3'b010, 3'b000, 0, 1, 0);
    add(0, 2'b00, 3'b010, 0, 0, 2'd1, 3'b010, 3'b000, 0, 0, 0);
    add(0, 2'b00, 3'b010, 0, 1, 2'd1, 3'b010, 3'b000, 0, 0, 0);
    add(0, 2'b00, 3'b010, 1, 1, 2'd1, 3'b010, 3'b010, 0, 0, 0);
    add(0, 2'b01, 3'b010, 0, 0, 2'd1, 3'b010, 3'b010, 0, 0, 1);
    add(0, 2'b01, 3'b010, 2, 1, 2'd1, 3'b010, 3'b010, 0, 0, 1);
    add(0, 2'b00, 3'b000, 0, 0, 2'd1, 3'b010, 3'b000, 0, 0, 1);
    // doors dropped while still opening: back to ALIGNED, full count again
    add(0, 2'b00, 3'b010, 0, 0, 2'd1, 3'b010, 3'b000, 0, 0, 1);
    add(0, 2'b00, 3'b000, 0, 1, 2'd1, 3'b010, 3'b000, 0, 0, 1);
    add(0, 2'b00, 3'b010, 0, 1, 2'd1, 3'b010, 3'b000, 0, 0, 1);
    add(0, 2'b00, 3'b010, 0, 1, 2'd1, 3'b010, 3'b000, 0, 0, 1);
    add(0, 2'b00, 3'b010, 0, 1, 2'd1, 3'b010, 3'b010, 0, 0, 1);
    add(0, 2'b00, 3'b000, 0, 0, 2'd1, 3'b010, 3'b000, 0, 0, 1);
    // Test 4: up 3 ticks, halt 5 ticks, reverse, back in 3 ticks
    add(1, 2'b01, 3'b000, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b00, 3'b000, 0, 0, 2'd0, 3'b000, 3'b000, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 2'b00, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 0, 0, 0);
    add(0, 2'b10, 3'b000, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b10, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b10, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b10, 3'b000, 0, 1, 2'd0, 3'b001, 3'b000, 0, 1, 0);
    add(0, 2'b00, 3'b000, 0, 0, 2'd0, 3'b001, 3'b000, 0, 0, 0);
    // Test 5: door request while travelling
    add(0, 2'b01, 3'b000, 0, 0, 2'd0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 2'b01, 3'b001, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 1);
    // Test 6: illegal engine, then tick coinciding with command changes
    add(1, 2'b11, 3'b000, 0, 1, 2'd0, 3'b001, 3'b000, 0, 0, 1);
    add(0, 2'b01, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 1);
    add(0, 2'b01, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 1);
    add(0, 2'b01, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 1);
    add(0, 2'b01, 3'b000, 0, 1, 2'd0, 3'b000, 3'b000, 1, 0, 1);
    add(0, 2'b01, 3'b000, 0, 1, 2'd1, 3'b010, 3'b000, 0, 1, 1);
    add(0, 2'b00, 3'b000, 0, 0, 2'd1, 3'b010, 3'b000, 0, 0, 1);
    add(0, 2'b10, 3'b000, 0, 0, 2'd1, 3'b000, 3'b000, 1, 0, 1);
    add(0, 2'b00, 3'b000, 0, 1, 2'd1, 3'b000, 3'b000, 0, 0, 1);
    add(0, 2'b10, 3'b000, 0, 0, 2'd1, 3'b000, 3'b000, 1, 0, 1);
    add(0, 2'b10, 3'b000, 0, 1, 2'd1, 3'b000, 3'b000, 1, 0, 1);
    add(0, 2'b10, 3'b000, 0, 1, 2'd1, 3'b000, 3'b000, 1, 0, 1);
    add(0, 2'b10, 3'b000, 0, 1, 2'd0, 3'b001, 3'b000, 0, 1, 1);

    // Reset values, both before and across a clock edge
    #12;
    check("reset_async", outs(), RESET_EXP);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("reset_idle", outs(), RESET_EXP);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) pulse_reset();
      engine = vt[i].eng;
      doors  = vt[i].drs;
      for (int j = 0; j < vt[i].idle; j++) cycle(1'b0);
      cycle(vt[i].tk);
      check($sformatf("vec%0d", i), outs(),
            {vt[i].pos, vt[i].fs, vt[i].dop, vt[i].mv, vt[i].arr, vt[i].flt});
    end

    // Door request naming another floor: fault, door stays shut
    pulse_reset();
    engine = 2'b00; doors = 3'b010;
    cycle(1'b1);
    check("wrong_floor_door", outs(), {2'd0, 3'b001, 3'b000, 1'b0, 1'b0, 1'b1});
    cycle(1'b1);
    cycle(1'b1);
    check("wrong_floor_still_shut", outs(), {2'd0, 3'b001, 3'b000, 1'b0, 1'b0, 1'b1});

    // Asynchronous reset in mid-travel
    pulse_reset();
    engine = 2'b01; doors = 3'b000;
    cycle(1'b1);
    check("pre_reset_travel", outs(), {2'd0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0});
    #2;
    RST = 1'b0;
    #1;
    check("async_reset_travel", outs(), RESET_EXP);
    #1;
    RST = 1'b1;
    engine = 2'b00;
    @(posedge CLK);
    #1;

    // Asynchronous reset with a door open
    doors = 3'b001;
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    check("pre_reset_door", outs(), {2'd0, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0});
    #2;
    RST = 1'b0;
    #1;
    check("async_reset_door", outs(), RESET_EXP);
    #1;
    RST = 1'b1;
    doors = 3'b000;
    @(posedge CLK);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
